// File: rtl/updown_counter_param_if.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_param_if
// Description : Control/status bundle for the parametrised up/down counter.
//               The harness side (master) drives the controls and bounds;
//               the counter side (slave) returns the count and flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface updown_counter_param_if #(
    parameter int WIDTH = 8
);
    // Controls
    logic             clr;
    logic             en;
    logic             up_down;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] step;
    logic [1:0]       mode;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;

    // Status
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrapped;
    logic             halted;
    logic             cfg_err;

    modport master (
        output clr, en, up_down, load, load_val, step, mode, lo, hi,
        input  count, tc, wrapped, halted, cfg_err
    );

    modport slave (
        input  clr, en, up_down, load, load_val, step, mode, lo, hi,
        output count, tc, wrapped, halted, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/updown_counter_param.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_param
// Description : Parametrised up/down counter with runtime bounds, step,
//               parallel load, wrap/saturate/one-shot modes and status flags.
//               All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_counter_param #(
    parameter int WIDTH     = 8,
    parameter int RESET_VAL = 0
) (
    input  wire                   clk,
    input  wire                   rst_n,
    updown_counter_param_if.slave bus
);

    localparam logic [WIDTH-1:0] c_RESET_VAL = WIDTH'(RESET_VAL);
    localparam logic [1:0]       c_MODE_SAT  = 2'b01;
    localparam logic [1:0]       c_MODE_ONE  = 2'b10;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_wrapped;
    logic             r_halted;
    logic             r_cfg_err;

    // ------------------------------------------------------------------
    // Arithmetic: one extra bit so neither a carry nor a borrow is lost
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic             w_cross_up;
    logic             w_cross_dn;
    logic             w_cross;
    logic [WIDTH-1:0] w_nxt;
    logic [WIDTH-1:0] w_wrap_target;
    logic [WIDTH-1:0] w_sat_target;
    logic [WIDTH-1:0] w_load_clamped;
    logic             w_run;

    assign w_sum    = {1'b0, r_count} + {1'b0, bus.step};
    assign w_diff   = {1'b0, r_count} - {1'b0, bus.step};
    assign w_borrow = w_diff[WIDTH];

    // Landing exactly on a bound is not a crossing; a borrow always is.
    assign w_cross_up = (w_sum > {1'b0, bus.hi});
    assign w_cross_dn = w_borrow || (w_diff[WIDTH-1:0] < bus.lo);
    assign w_cross    = bus.up_down ? w_cross_dn : w_cross_up;
    assign w_nxt      = bus.up_down ? w_diff[WIDTH-1:0] : w_sum[WIDTH-1:0];

    // Wrap re-enters at the opposite bound; saturate/one-shot stick to the
    // bound that was crossed.
    assign w_wrap_target = bus.up_down ? bus.hi : bus.lo;
    assign w_sat_target  = bus.up_down ? bus.lo : bus.hi;

    assign w_load_clamped = (bus.load_val < bus.lo) ? bus.lo :
                            (bus.load_val > bus.hi) ? bus.hi : bus.load_val;

    // Counting is frozen by a finished one-shot or an inverted bound pair.
    assign w_run = bus.en && !r_halted && !r_cfg_err && (bus.step != '0);

    // ------------------------------------------------------------------
    // Next-state selection: clr > load > counting > hold
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_count_d;
    logic             w_tc_d;
    logic             w_wrapped_d;
    logic             w_halted_d;

    // Choose next count and flags from the prioritised controls
    always_comb begin
        w_count_d   = r_count;
        w_tc_d      = 1'b0;
        w_wrapped_d = r_wrapped;
        w_halted_d  = r_halted;

        if (bus.clr) begin
            w_count_d   = bus.lo;
            w_wrapped_d = 1'b0;
            w_halted_d  = 1'b0;
        end else if (bus.load) begin
            // With inverted bounds there is no meaningful clamp range.
            w_count_d  = r_cfg_err ? bus.load_val : w_load_clamped;
            w_halted_d = 1'b0;
        end else if (w_run) begin
            if (!w_cross) begin
                w_count_d = w_nxt;
            end else begin
                case (bus.mode)
                    c_MODE_SAT: begin
                        // Only the step that first lands on the bound pulses.
                        w_count_d = w_sat_target;
                        w_tc_d    = (r_count != w_sat_target);
                    end
                    c_MODE_ONE: begin
                        w_count_d  = w_sat_target;
                        w_tc_d     = 1'b1;
                        w_halted_d = 1'b1;
                    end
                    default: begin
                        // Mode 11 behaves as wrap; excess beyond the bound is dropped.
                        w_count_d   = w_wrap_target;
                        w_tc_d      = 1'b1;
                        w_wrapped_d = 1'b1;
                    end
                endcase
            end
        end
    end

    // Register count, flags and the bound-sanity flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= c_RESET_VAL;
            r_tc      <= 1'b0;
            r_wrapped <= 1'b0;
            r_halted  <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_count   <= w_count_d;
            r_tc      <= w_tc_d;
            r_wrapped <= w_wrapped_d;
            r_halted  <= w_halted_d;
            r_cfg_err <= (bus.lo > bus.hi);
        end
    end

    assign bus.count   = r_count;
    assign bus.tc      = r_tc;
    assign bus.wrapped = r_wrapped;
    assign bus.halted  = r_halted;
    assign bus.cfg_err = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_updown_counter_param
// Description : Self-checking bench for updown_counter_param (WIDTH=8,
//               RESET_VAL=3). Table of vectors plus hand-written sequences
//               for the full wrap sweep and the asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_counter_param;

    localparam int WIDTH     = 8;
    localparam int RESET_VAL = 3;
    localparam int NVEC      = 32;

    typedef struct packed {
        logic [WIDTH-1:0] count;
        logic             tc;
        logic             wrapped;
        logic             halted;
        logic             cfg_err;
    } exp_t;

    typedef struct {
        logic             clr;
        logic             load;
        logic             en;
        logic             up_down;
        logic [1:0]       mode;
        logic [WIDTH-1:0] load_val;
        logic [WIDTH-1:0] step;
        logic [WIDTH-1:0] lo;
        logic [WIDTH-1:0] hi;
        exp_t             exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    exp_t sb_q[$];
    vec_t vecs[NVEC];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    updown_counter_param_if #(.WIDTH(WIDTH)) bus ();

    updown_counter_param #(
        .WIDTH    (WIDTH),
        .RESET_VAL(RESET_VAL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    function automatic exp_t mk_exp(input int c, input bit t, input bit w,
                                    input bit h, input bit e);
        exp_t x;
        x.count   = WIDTH'(c);
        x.tc      = t;
        x.wrapped = w;
        x.halted  = h;
        x.cfg_err = e;
        return x;
    endfunction

    function automatic vec_t mk_vec(input bit c, input bit l, input bit en,
                                    input bit ud, input int md, input int lv,
                                    input int st, input int lo, input int hi,
                                    input exp_t x);
        vec_t v;
        v.clr      = c;
        v.load     = l;
        v.en       = en;
        v.up_down  = ud;
        v.mode     = 2'(md);
        v.load_val = WIDTH'(lv);
        v.step     = WIDTH'(st);
        v.lo       = WIDTH'(lo);
        v.hi       = WIDTH'(hi);
        v.exp      = x;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.clr      = v.clr;
        bus.load     = v.load;
        bus.en       = v.en;
        bus.up_down  = v.up_down;
        bus.mode     = v.mode;
        bus.load_val = v.load_val;
        bus.step     = v.step;
        bus.lo       = v.lo;
        bus.hi       = v.hi;
    endtask

    // Pop the oldest expectation and compare it with the live outputs.
    task automatic compare_out(input string name);
        exp_t e;
        exp_t got;
        n_checks++;
        got = {bus.count, bus.tc, bus.wrapped, bus.halted, bus.cfg_err};
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got count=%0d", name, got.count);
        end else begin
            e = sb_q.pop_front();
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s: got count=%0d tc=%0b wrapped=%0b halted=%0b cfg_err=%0b, expected count=%0d tc=%0b wrapped=%0b halted=%0b cfg_err=%0b",
                         name, got.count, got.tc, got.wrapped, got.halted, got.cfg_err,
                         e.count, e.tc, e.wrapped, e.halted, e.cfg_err);
            end
        end
    endtask

    // Drive stimulus, queue its expectation, sample #1 after the next edge.
    task automatic apply(input vec_t v, input string name);
        drive(v);
        sb_q.push_back(v.exp);
        @(posedge clk);
        #1;
        compare_out(name);
    endtask

    initial begin
        vec_t v;

        // Saturate block: lo=10 hi=20 step=3
        vecs[0]  = mk_vec(1,0,0,0,1, 0,3,10,20, mk_exp(10,0,0,0,0));
        vecs[1]  = mk_vec(0,1,0,0,1,18,3,10,20, mk_exp(18,0,0,0,0));
        vecs[2]  = mk_vec(0,0,1,0,1, 0,3,10,20, mk_exp(20,1,0,0,0));
        vecs[3]  = mk_vec(0,0,1,0,1, 0,3,10,20, mk_exp(20,0,0,0,0));
        vecs[4]  = mk_vec(0,0,1,1,1, 0,3,10,20, mk_exp(17,0,0,0,0));
        vecs[5]  = mk_vec(0,0,1,1,1, 0,3,10,20, mk_exp(14,0,0,0,0));
        vecs[6]  = mk_vec(0,0,1,1,1, 0,3,10,20, mk_exp(11,0,0,0,0));
        vecs[7]  = mk_vec(0,0,1,1,1, 0,3,10,20, mk_exp(10,1,0,0,0));
        vecs[8]  = mk_vec(0,0,1,1,1, 0,3,10,20, mk_exp(10,0,0,0,0));
        // One-shot down: lo=0 hi=5 step=2
        vecs[9]  = mk_vec(0,1,0,1,2, 5,2,0,5,   mk_exp(5,0,0,0,0));
        vecs[10] = mk_vec(0,0,1,1,2, 0,2,0,5,   mk_exp(3,0,0,0,0));
        vecs[11] = mk_vec(0,0,1,1,2, 0,2,0,5,   mk_exp(1,0,0,0,0));
        vecs[12] = mk_vec(0,0,1,1,2, 0,2,0,5,   mk_exp(0,1,0,1,0));
        vecs[13] = mk_vec(0,0,1,1,2, 0,2,0,5,   mk_exp(0,0,0,1,0));
        vecs[14] = mk_vec(0,1,1,1,2, 4,2,0,5,   mk_exp(4,0,0,0,0));
        // Priority and clamping: lo=2 hi=20
        vecs[15] = mk_vec(0,1,0,0,0, 7,5,2,20,  mk_exp(7,0,0,0,0));
        vecs[16] = mk_vec(1,1,1,0,0, 9,5,2,20,  mk_exp(2,0,0,0,0));
        vecs[17] = mk_vec(0,1,0,0,0,50,5,2,20,  mk_exp(20,0,0,0,0));
        vecs[18] = mk_vec(0,1,0,0,0, 0,5,2,20,  mk_exp(2,0,0,0,0));
        // Wrap with borrow / overshoot, mode 11 as wrap
        vecs[19] = mk_vec(0,0,1,1,0, 0,5,2,20,  mk_exp(20,1,1,0,0));
        vecs[20] = mk_vec(0,0,1,0,0, 0,5,2,20,  mk_exp(2,1,1,0,0));
        vecs[21] = mk_vec(0,0,1,0,3, 0,18,2,20, mk_exp(20,0,1,0,0));
        vecs[22] = mk_vec(0,0,1,0,3, 0,18,2,20, mk_exp(2,1,1,0,0));
        // Count above hi after bounds shrink; step=0 holds
        vecs[23] = mk_vec(0,0,1,0,1, 0,1,0,1,   mk_exp(1,1,1,0,0));
        vecs[24] = mk_vec(0,0,1,0,1, 0,0,0,1,   mk_exp(1,0,1,0,0));
        // Carry beyond WIDTH must saturate, not alias to a small value
        vecs[25] = mk_vec(0,1,0,0,1,250,10,0,255, mk_exp(250,0,1,0,0));
        vecs[26] = mk_vec(0,0,1,0,1, 0,10,0,255,  mk_exp(255,1,1,0,0));
        // Inverted bounds
        vecs[27] = mk_vec(0,0,0,0,1, 0,1,30,10,   mk_exp(255,0,1,0,1));
        vecs[28] = mk_vec(0,0,1,0,1, 0,1,30,10,   mk_exp(255,0,1,0,1));
        vecs[29] = mk_vec(0,1,0,0,1,50,1,30,10,   mk_exp(50,0,1,0,1));
        vecs[30] = mk_vec(0,0,0,0,0, 0,1,0,255,   mk_exp(50,0,1,0,0));
        vecs[31] = mk_vec(0,0,1,0,0, 0,1,0,255,   mk_exp(51,0,1,0,0));

        // Reset state
        rst_n = 1'b0;
        drive(mk_vec(0,0,0,0,0,0,1,0,255, mk_exp(0,0,0,0,0)));
        #12;
        sb_q.push_back(mk_exp(RESET_VAL,0,0,0,0));
        compare_out("reset_state");
        rst_n = 1'b1;

        // Full wrap sweep from 0 over 256 enabled cycles
        apply(mk_vec(1,0,0,0,0,0,1,0,255, mk_exp(0,0,0,0,0)), "sweep_clr");
        for (int i = 0; i < 256; i++) begin
            v = mk_vec(0,0,1,0,0,0,1,0,255,
                       mk_exp((i + 1) % 256, (i == 255), (i == 255), 0, 0));
            apply(v, $sformatf("sweep%0d", i));
        end
        apply(mk_vec(0,0,0,0,0,0,1,0,255, mk_exp(0,0,1,0,0)), "sweep_idle");

        // Table vectors
        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset between edges, then resume from RESET_VAL
        apply(mk_vec(0,0,1,0,0,0,1,0,255, mk_exp(52,0,1,0,0)), "pre_reset");
        #3;
        rst_n = 1'b0;
        #1;
        sb_q.push_back(mk_exp(RESET_VAL,0,0,0,0));
        compare_out("async_reset");
        rst_n = 1'b1;
        apply(mk_vec(0,0,1,0,0,0,1,0,255, mk_exp(RESET_VAL + 1,0,0,0,0)), "resume1");
        apply(mk_vec(0,0,1,0,0,0,1,0,255, mk_exp(RESET_VAL + 2,0,0,0,0)), "resume2");

        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised up/down counter for the FPGA test IO harness; next generation of the fixed 4-bit rst/up_down test counter.
- Adds:
  - configurable width;
  - runtime bounds, step and parallel load;
  - wrap / saturate / one-shot modes;
  - terminal-count and status flags.
- The top-level test wrapper maps control bits from IN[] and drives count and flags onto OUT[].

Parameters:
- WIDTH, 8, counter/bound/step width in bits (2..32).
- RESET_VAL, 0, count value on reset (must fit WIDTH).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear: count to lo, clears flags.
- en  in  1  count enable.
- up_down  in  1  direction: 0 = up, 1 = down.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- step  in  WIDTH  increment magnitude.
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
- lo  in  WIDTH  lower bound, unsigned.
- hi  in  WIDTH  upper bound, unsigned.
- count  out  WIDTH  registered count.
- tc  out  1  one-cycle pulse on bound crossing.
- wrapped  out  1  sticky: a wrap has occurred.
- halted  out  1  one-shot finished; counting frozen.
- cfg_err  out  1  lo > hi, registered each cycle.

Behaviour:
- Reset (rst_n low, async): count=RESET_VAL; tc=0, wrapped=0, halted=0, cfg_err=0. Deassertion takes effect at the next clk edge.
- All outputs are registered. A control change is visible on count one cycle after the sampling edge.
- Priority per edge: clr > load > (en & !halted & !cfg_err) counting > hold.
- cfg_err is registered from (lo > hi) every cycle. While it is set:
  - count holds;
  - clr and load still operate, but load skips clamping and takes load_val raw.
- clr: count=lo; tc=0, wrapped=0, halted=0.
- load:
  - count = load_val clamped to [lo, hi];
  - halted is cleared; wrapped is unchanged; tc=0.
- Counting arithmetic is WIDTH+1 bits unsigned, so there is no silent modular overflow.
  - Up: nxt = count + step.
  - Down: nxt = count - step; a borrow counts as below lo.
- Crossing, up: nxt > hi. Crossing, down: nxt < lo or borrow.
  - Reaching a bound exactly is not a crossing.
- No crossing: count = nxt; tc=0.
- Crossing, per mode:
  - wrap: count = lo (up) or hi (down), excess discarded; tc=1 for one cycle; wrapped=1.
  - saturate: count = hi (up) or lo (down); tc=1 only on the first cycle of reaching saturation. Further saturated steps give tc=0 and count holds.
  - one-shot: count = hi (up) or lo (down); tc=1; halted=1. halted clears only on clr, load or reset.
- step=0: count holds; tc=0.
- Counting with count outside [lo, hi] (bounds changed after the count settled): the crossing rules apply as written.
  - Example: up with count > hi is a crossing.
- en=0: count holds; tc=0.
- Mode, direction, bounds and step may change on any cycle; each edge uses the values sampled at that edge.
- Reset mid-count: immediate async return to reset values; no partial tc pulse.

Test Plan:
- WIDTH=8, lo=0, hi=255, step=1, mode=wrap, up: reset, en=1 for 256 cycles -> count 1..255 then 0. tc=1 only on the 255->0 edge; wrapped=1 afterwards.
- lo=10, hi=20, step=3, mode=saturate, load 18, up -> count 20, tc=1 one cycle. Next enabled cycle -> count 20, tc=0. Switch up_down=1 -> 17, 14, 11, 10 (tc=1 at 10).
- mode=one-shot, lo=0, hi=5, step=2, down from load 5 -> 3, 1, 0 with tc=1 and halted=1. Further en cycles -> count 0, tc=0. Then load 4 -> count 4, halted=0.
- Simultaneous clr, load and en in one cycle with count=7, lo=2 -> count 2, flags cleared. load alone with load_val=50, hi=20 -> count 20 (clamped).
- lo=30, hi=10 -> cfg_err=1 the next cycle, count holds under en. Restore lo=0 -> cfg_err=0 and counting resumes.
- Assert rst_n=0 asynchronously between edges mid-count with RESET_VAL=3 -> count=3 and all flags 0 before the next edge. Release -> counting resumes from 3.
